// File: rtl/divisor_4bits.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock; done follows the accept edge by WIDTH+1 cycles.
// start is ignored while busy. Results and the divide-by-zero flag are registered and held until the next done.
module divisor_4bits #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rout_q, rout_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // rem_q never exceeds the divisor, so its top bit is zero and trial's MSB is the borrow.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (trial[WIDTH+1]) begin
                    rem_d = shifted[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                quo_d   = dvd_q;
                rout_d  = rem_q[WIDTH-1:0];
                dbz_d   = (dvs_q == '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rout_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divisor_4bits.sv
// Directed bench for divisor_4bits: reset, back-to-back stream, boundaries, divide by zero, protocol and an all-pairs sweep.
module tb_divisor_4bits;
    localparam int W = 4;

    logic         clock;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors;
    int miscompares;

    divisor_4bits #(.WIDTH(W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns at the negedge where done is high.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int n;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clock);
        start    = 1'b0;
        dividend = W'($urandom_range(0, 15));
        divisor  = W'($urandom_range(0, 15));
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        check({tag, ".done_lo"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 12) begin
            @(negedge clock);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(W + 1));
        check({tag, ".quot"}, 32'(quotient), 32'(eq));
        check({tag, ".rem"}, 32'(remainder), 32'(er));
        check({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    initial begin
        int n;
        int extra;
        logic [W-1:0] qm;
        logic [W-1:0] rm;
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.quot", 32'(quotient), 32'd0);
        check("rst.rem", 32'(remainder), 32'd0);
        check("rst.dbz", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        run_op("8/2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0);
        @(negedge clock);
        check("8/2.pulse", 32'(done), 32'd0);

        // Back-to-back stream: each start is raised in the previous done cycle.
        run_op("7/3", 4'd7, 4'd3, 4'd2, 4'd1, 1'b0);
        run_op("6/4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
        run_op("5/5", 4'd5, 4'd5, 4'd1, 4'd0, 1'b0);
        run_op("3/7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0);

        run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_op("0/9", 4'd0, 4'd9, 4'd0, 4'd0, 1'b0);
        run_op("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        run_op("1/15", 4'd1, 4'd15, 4'd0, 4'd1, 1'b0);

        run_op("5/0", 4'd5, 4'd0, 4'd15, 4'd5, 1'b1);
        run_op("9/4", 4'd9, 4'd4, 4'd2, 4'd1, 1'b0);

        // Reset mid-operation, applied between edges.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd2;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.quot", 32'(quotient), 32'd0);
        check("midrst.rem", 32'(remainder), 32'd0);
        check("midrst.dbz", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        count_dones(8, extra);
        check("midrst.no_done", 32'(extra), 32'd0);
        run_op("13/2", 4'd13, 4'd2, 4'd6, 4'd1, 1'b0);
        @(negedge clock);

        // start with new operands while busy must be ignored.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        @(negedge clock);
        start = 1'b0;
        n = 2;
        while (!done && n < 12) begin
            @(negedge clock);
            n++;
        end
        check("prot.latency", 32'(n), 32'(W + 1));
        check("prot.quot", 32'(quotient), 32'd4);
        check("prot.rem", 32'(remainder), 32'd2);
        count_dones(8, extra);
        check("prot.no_extra", 32'(extra), 32'd0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    qm = 4'd15;
                    rm = W'(a);
                end else begin
                    qm = W'(a / b);
                    rm = W'(a % b);
                end
                run_op("sweep", W'(a), W'(b), qm, rm, (b == 0));
                vectors++;
                if (b != 0) begin
                    assert ((32'(quotient) * 32'(b) + 32'(remainder) == 32'(a)) && (remainder < W'(b))) else begin
                        miscompares++;
                        $error("FAIL sweep.invariant %0d/%0d: observed q=%0d r=%0d", a, b, quotient, remainder);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/divisor_4bits.md
Name: divisor_4bits

Overview:
- Sequential unsigned integer divider: quotient and remainder of a WIDTH-bit dividend over a WIDTH-bit divisor (default 4 bits).
- Restoring shift-subtract algorithm, one quotient bit per clock, start/done handshake.
- Arithmetic leaf for datapath blocks that can tolerate a few cycles of latency.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag: last completed operation had divisor == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock port `clock`, reset port `rst_n`).
- Reset (rst_n low, any time, independent of clock):
  - state goes to IDLE.
  - busy, done, quotient, remainder and div_by_zero are all 0.
  - internal shift, accumulator and counter registers are cleared.
- Reset mid-operation: the operation is aborted and no done pulse is produced. After release the block is in IDLE and accepts the next start.
- States: IDLE, CALC, FINISH.
- IDLE:
  - busy = 0.
  - start = 1 at a rising edge: latch dividend and divisor, clear the partial remainder (WIDTH+1 bits), load counter = WIDTH, move to CALC.
  - start = 0: stay in IDLE.
- CALC (busy = 1), one iteration per edge:
  - shift {partial remainder, dividend shift register} left by one bit.
  - trial = partial remainder - divisor.
  - if trial is non-negative: keep trial and shift in quotient bit 1; otherwise restore and shift in 0.
  - decrement the counter; after WIDTH iterations move to FINISH.
- FINISH (busy = 1 for this one cycle):
  - on the next edge, write quotient, remainder and div_by_zero to the output registers.
  - pulse done high for exactly one cycle and return to IDLE.
- Latency:
  - start accepted at edge k; outputs updated and done = 1 after edge k+WIDTH+1.
  - busy is high from edge k to edge k+WIDTH+1.
  - WIDTH=4: done follows the accept edge by 5 cycles.
- Output hold: quotient, remainder and div_by_zero keep their values until the next done. They do not change during CALC.
- start while busy: ignored. Operands are not re-latched and the current operation is unaffected.
- start high in the same cycle as done: accepted, because the block is back in IDLE. The new operation begins on that edge (back-to-back throughput of one op per WIDTH+2 cycles).
- Changes on dividend/divisor after the accept edge: no effect on the running operation.
- Divide by zero (divisor == 0):
  - same latency as a normal operation.
  - quotient = all ones (15 for WIDTH=4), remainder = dividend, div_by_zero = 1.
  - the restoring algorithm produces exactly this naturally; no special path is needed except the flag.
- Invariant: for divisor != 0, dividend == quotient*divisor + remainder and remainder < divisor. div_by_zero = 0.
- All arithmetic is unsigned. The partial remainder is WIDTH+1 bits to hold the borrow. No overflow is possible.

Test Plan:
- Reset: hold rst_n low, then release; drive start=1, dividend=8, divisor=2 -> 5 cycles later done pulses one cycle with quotient=4, remainder=0, div_by_zero=0; busy=0 afterwards.
- Sweep as a back-to-back stream, start asserted in each done cycle: 7/3, 6/4, 5/5, 3/7 -> results (2,1), (1,2), (1,0), (0,3) in order, each exactly WIDTH+2 cycles apart.
- Boundaries: 15/1 -> (15,0); 0/9 -> (0,0); 15/15 -> (1,0); 1/15 -> (0,1).
- Divide by zero: 5/0 -> quotient=15, remainder=5, div_by_zero=1 after normal latency; a following 9/4 -> (2,1), div_by_zero=0.
- Protocol: start and new operands (e.g. 9/2) pulsed while busy during a 14/3 operation -> ignored, result is (4,2), no extra done.
- Reset mid-operation: start 13/2, assert rst_n low 2 cycles later (asynchronously, between edges) -> outputs 0 immediately, no done; after release 13/2 -> (6,1).
- Exhaustive: all 256 operand pairs checked against quotient*divisor + remainder == dividend and remainder < divisor, or the divide-by-zero rule when divisor == 0.
